// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    function automatic int cnt_width(input int half_period);
        return $clog2(2 * half_period + 1);
    endfunction

    function automatic int idx_width(input int data_bits, input int stop_bits);
        return $clog2(((data_bits > stop_bits) ? data_bits : stop_bits) + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic p_RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta_q <= p_RESET_VAL;
            sync_q <= p_RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, LSB-first data, configurable stop bits, no parity.
module uart_rx
    import uart_pkg::*;
#(
    parameter int p_BITSLOT_HALF_PERIOD = 434,
    parameter int p_DATA_BITS           = 8,
    parameter int p_STOP_BITS           = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rx,
    output logic [p_DATA_BITS-1:0] o_data,
    output logic                   o_data_ready
);

    localparam int CW = cnt_width(p_BITSLOT_HALF_PERIOD);
    localparam int IW = idx_width(p_DATA_BITS, p_STOP_BITS);

    // Counters count down to zero, so each load is one less than the slot length.
    localparam logic [CW-1:0] HALF_M1   = CW'(p_BITSLOT_HALF_PERIOD - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(2 * p_BITSLOT_HALF_PERIOD - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(p_DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(p_STOP_BITS - 1);

    logic rx_s;

    sync_2ff #(.p_RESET_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [p_DATA_BITS-1:0] shift_q, shift_d;
    logic [p_DATA_BITS-1:0] data_q, data_d;
    logic                   ready_q, ready_d;
    logic [p_DATA_BITS-1:0] shift_in;
    logic                   sample;

    // New bits enter at the MSB so the first received bit ends up at bit 0.
    generate
        if (p_DATA_BITS == 1) begin : g_shift_one
            assign shift_in = rx_s;
        end else begin : g_shift_many
            assign shift_in = {rx_s, shift_q[p_DATA_BITS-1:1]};
        end
    endgenerate

    assign sample = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end
            end
            START: begin
                if (!sample) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s) begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = FULL_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!sample) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = shift_in;
                    cnt_d   = FULL_M1;
                    if (idx_q == LAST_DATA) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            STOP: begin
                if (!sample) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s) begin
                    state_d = WAIT_IDLE;
                end else if (idx_q == LAST_STOP) begin
                    data_d  = shift_q;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                    cnt_d = FULL_M1;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break never frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_ready = ready_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner cases plus a randomized frame table.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [0:0] data_a;
    logic [7:0] data_b, data_c;
    logic       rdy_a, rdy_b, rdy_c;

    always #5 clk = ~clk;

    // A: H=1 N=1 S=3   B: H=4 N=8 S=1   C: H=4 N=8 S=2
    uart_rx #(.p_BITSLOT_HALF_PERIOD(1), .p_DATA_BITS(1), .p_STOP_BITS(3)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_data(data_a), .o_data_ready(rdy_a));
    uart_rx #(.p_BITSLOT_HALF_PERIOD(4), .p_DATA_BITS(8), .p_STOP_BITS(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .o_data(data_b), .o_data_ready(rdy_b));
    uart_rx #(.p_BITSLOT_HALF_PERIOD(4), .p_DATA_BITS(8), .p_STOP_BITS(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_c), .o_data(data_c), .o_data_ready(rdy_c));

    int unsigned cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          viol_b = 0;
    logic        rst_at_edge = 1'b1;
    logic [7:0]  prev_b = 8'h00;

    logic [7:0]  got_a[$], got_b[$], got_c[$];
    int unsigned t_b[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_at_edge <= !rst_n;
    end

    always @(negedge clk) begin
        if (rdy_a) got_a.push_back({7'b0, data_a});
        if (rdy_c) got_c.push_back(data_c);
        if (rdy_b) begin
            got_b.push_back(data_b);
            t_b.push_back(cyc);
        end
        if (!rst_at_edge && !rdy_b && data_b != prev_b) viol_b++;
        prev_b = data_b;
    end

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int which, input logic v);
        case (which)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Drives nbits bits LSB-first, each held for 2*h clocks.
    task automatic drive_bits(input int which, input int h, input logic [31:0] bits,
                              input int nbits);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, bits[i]);
            wait_clk(2 * h);
        end
    endtask

    task automatic send_b(input logic [7:0] d, input logic stop);
        logic [31:0] w;
        w = {22'b0, stop, d, 1'b0};
        drive_bits(1, 4, w, 10);
        $display("tx B: data=%02h stop=%0b", d, stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         gap;
        logic       exp_strobe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl[24];
    logic [7:0] exp_q[$];

    initial begin
        int base, n_before;
        logic [7:0] held;
        logic [31:0] w;

        wait_clk(3);
        check("reset data_a", data_a, 0);
        check("reset rdy_a", rdy_a, 0);
        check("reset data_b", data_b, 0);
        check("reset rdy_b", rdy_b, 0);
        check("reset data_c", data_c, 0);
        rst_n = 1'b1;
        wait_clk(2);

        // 1: minimal frame on A
        wait_clk(5);
        rx_a = 1'b0;
        wait_clk(2);
        rx_a = 1'b1;
        wait_clk(60);
        check("t1 strobes", got_a.size(), 1);
        check("t1 data", got_a[0], 1);
        $display("t1: strobes=%0d", got_a.size());

        // 2: back-to-back frames on B
        send_b(8'hA5, 1'b1);
        send_b(8'h3C, 1'b1);
        wait_clk(40);
        check("t2 strobes", got_b.size(), 2);
        check("t2 first", got_b[0], 8'hA5);
        check("t2 second", got_b[1], 8'h3C);
        check("t2 spacing", t_b[1] - t_b[0], 80);

        // 3: glitch shorter than half a bit
        rx_b = 1'b0;
        wait_clk(2);
        rx_b = 1'b1;
        wait_clk(100);
        check("t3 no strobe", got_b.size(), 2);
        check("t3 data held", data_b, 8'h3C);
        $display("t3: glitch, data_b=%02h", data_b);

        // 4: framing error on second stop bit (C)
        w = {21'b0, 2'b01, 8'h55, 1'b0};
        drive_bits(2, 4, w, 11);
        rx_c = 1'b1;
        wait_clk(20);
        check("t4 bad frame no strobe", got_c.size(), 0);
        check("t4 data unchanged", data_c, 0);
        w = {21'b0, 2'b11, 8'h81, 1'b0};
        drive_bits(2, 4, w, 11);
        wait_clk(20);
        check("t4 strobes", got_c.size(), 1);
        check("t4 data", got_c[0], 8'h81);
        $display("t4: good frame data_c=%02h", data_c);

        // 5: stuck-low line
        n_before = got_b.size();
        rx_b = 1'b0;
        wait_clk(200);
        check("t5 no strobe while low", got_b.size(), n_before);
        rx_b = 1'b1;
        wait_clk(20);
        send_b(8'h0F, 1'b1);
        wait_clk(20);
        check("t5 strobes", got_b.size(), n_before + 1);
        check("t5 data", got_b[got_b.size() - 1], 8'h0F);

        // 6: reset during data bit 3 (bits 3..7 high so no false start afterwards)
        n_before = got_b.size();
        fork
            send_b(8'hF9, 1'b1);
            begin
                wait_clk(35);
                rst_n = 1'b0;
                wait_clk(1);
                rst_n = 1'b1;
                check("t6 data after reset", data_b, 0);
                check("t6 rdy after reset", rdy_b, 0);
            end
        join
        wait_clk(20);
        check("t6 no strobe", got_b.size(), n_before);
        send_b(8'h3A, 1'b1);
        wait_clk(20);
        check("t6 next frame count", got_b.size(), n_before + 1);
        check("t6 next frame data", got_b[got_b.size() - 1], 8'h3A);

        // Table: fixed corner entries, then random frames
        tbl[0] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
        tbl[1] = '{8'hFF, 1'b1, 0, 1'b0, 8'h00};
        tbl[2] = '{8'h5A, 1'b0, 3, 1'b0, 8'h00};
        tbl[3] = '{8'h81, 1'b1, 0, 1'b0, 8'h00};
        for (int i = 4; i < 24; i++) begin
            tbl[i].data    = 8'($urandom);
            tbl[i].stop_ok = ($urandom_range(0, 3) != 0);
            tbl[i].gap     = tbl[i].stop_ok ? int'($urandom_range(0, 10))
                                            : int'($urandom_range(2, 10));
        end
        held = 8'h3A;
        for (int i = 0; i < 24; i++) begin
            tbl[i].exp_strobe = tbl[i].stop_ok;
            if (tbl[i].stop_ok) held = tbl[i].data;
            tbl[i].exp_data = held;
            if (tbl[i].exp_strobe) exp_q.push_back(tbl[i].data);
        end

        base = got_b.size();
        for (int i = 0; i < 24; i++) begin
            send_b(tbl[i].data, tbl[i].stop_ok);
            rx_b = 1'b1;
            wait_clk(tbl[i].gap);
        end
        wait_clk(20);
        check("tbl strobe count", got_b.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("tbl word %0d", k), got_b[base + k], exp_q[k]);
            $display("rx B: word %0d got=%02h exp=%02h", k, got_b[base + k], exp_q[k]);
        end
        check("tbl final data", data_b, tbl[23].exp_data);
        check("data_b changed without strobe", viol_b, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
